// File: rtl/i2c_fifo_drain_if.sv
// FIFO read-port bundle between the DSP->I2C FIFO and the I2C drain.
// master = FIFO side (supplies head word), slave = drain side (issues pops).
interface i2c_fifo_drain_if #(
  parameter int DATASIZE = 8,
  parameter int CNTSIZE  = 8
);
  logic [DATASIZE-1:0] dout;
  logic                doutV;
  logic                doutR;
  logic [CNTSIZE-1:0]  cnt;

  modport master (output dout, output doutV, output cnt, input doutR);
  modport slave  (input dout, input doutV, input cnt, output doutR);
endinterface

// File: rtl/i2c_fifo_drain.sv
// I2C target transmitter draining the DSP->I2C FIFO.
// A read addressed to ADDR returns the FIFO occupancy byte, then pops FIFO
// words MSB-first for as long as the master keeps ACKing. Writes are NACKed.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | bus free, SDA released, waiting for START
//   S_ADDR      | shifting in 7-bit address + R/W
//   S_ACK_ADDR  | driving address ACK; next SCL fall loads the cnt byte
//   S_TX_BYTE   | presenting data bits on SCL falls
//   S_RX_ACK    | SDA released, sampling master ACK/NACK on the 9th rise
//   S_WAIT_STOP | not addressed / master NACKed; ignore bus until START/STOP
module i2c_fifo_drain #(
  parameter logic [6:0] ADDR     = 7'h42,
  parameter int         DATASIZE = 8,
  parameter int         CNTSIZE  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scl_in,
  input  logic            sda_in,
  output logic            sda_oe,
  output logic            busy,
  i2c_fifo_drain_if.slave fifo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_ADDR,
    S_TX_BYTE,
    S_RX_ACK,
    S_WAIT_STOP
  } state_t;

  state_t state_q, state_d;

  logic scl_s1, scl_s2, scl_prev;
  logic sda_s1, sda_s2, sda_prev;
  logic scl_rise, scl_fall, start_evt, stop_evt;

  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_d;
  logic       busy_d;
  logic       nack_q, nack_d;
  logic       pop;

  logic [DATASIZE-1:0] dout_raw;
  logic [CNTSIZE-1:0]  cnt_raw;
  logic [7:0]          dout_byte;
  logic [7:0]          cnt_byte;
  logic [7:0]          next_byte;
  logic                addr_hit;
  logic                rd_req;

  assign dout_raw  = fifo.dout;
  assign cnt_raw   = fifo.cnt;
  assign dout_byte = 8'(dout_raw);
  assign cnt_byte  = 8'(cnt_raw);
  assign next_byte = fifo.doutV ? dout_byte : 8'h00;

  assign addr_hit  = (shift_q[7:1] == ADDR);
  assign rd_req    = shift_q[0];

  // Two-flop synchronizers plus a history flop for edge detection.
  // Reset to the idle-bus level so release from reset never fakes an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= scl_in;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda_in;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
    end
  end

  assign scl_rise  =  scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 &  scl_prev;
  assign start_evt =  scl_s2 &  sda_prev & ~sda_s2;
  assign stop_evt  =  scl_s2 & ~sda_prev &  sda_s2;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      nack_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      nack_q    <= nack_d;
    end
  end

  // Next-state logic; START and STOP override whatever state we are in.
  always_comb begin
    state_d = state_q;
    if (start_evt) begin
      state_d = S_ADDR;
    end else if (stop_evt) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR:
          if (scl_fall && bit_cnt_q == 4'd8)
            state_d = (addr_hit && rd_req) ? S_ACK_ADDR : S_WAIT_STOP;
        S_ACK_ADDR:
          if (scl_fall) state_d = S_TX_BYTE;
        S_TX_BYTE:
          if (scl_fall && bit_cnt_q == 4'd7) state_d = S_RX_ACK;
        S_RX_ACK:
          if (scl_fall) state_d = nack_q ? S_WAIT_STOP : S_TX_BYTE;
        default: state_d = state_q;
      endcase
    end
  end

  // Output/datapath logic: SDA drive only changes on a detected SCL fall.
  always_comb begin
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    nack_d    = nack_q;
    pop       = 1'b0;
    if (start_evt) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
    end else if (stop_evt) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s2};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = addr_hit && rd_req;
            busy_d   = addr_hit && rd_req;
          end
        end
        S_ACK_ADDR: begin
          if (scl_fall) begin
            shift_d   = cnt_byte;
            sda_oe_d  = ~cnt_byte[7];
            bit_cnt_d = 4'd0;
          end
        end
        S_TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              nack_d   = 1'b1;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RX_ACK: begin
          if (scl_rise) nack_d = sda_s2;
          if (scl_fall) begin
            if (!nack_q) begin
              shift_d   = next_byte;
              sda_oe_d  = ~next_byte[7];
              bit_cnt_d = 4'd0;
              pop       = fifo.doutV;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        default: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // Pop strobe coincides with the clk edge that loads the head word.
  assign fifo.doutR = pop & ~reset;

endmodule

// File: tb/tb_i2c_fifo_drain.sv
// Bit-banged I2C master against i2c_fifo_drain with a FIFO model and a
// byte scoreboard (expected bytes queued at stimulus, checked by a monitor).
module tb_i2c_fifo_drain;

  localparam int Q = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy;
  logic sda_bus;

  always #5 clk = ~clk;

  i2c_fifo_drain_if #(.DATASIZE(8), .CNTSIZE(8)) fifo_bus ();

  i2c_fifo_drain #(.ADDR(7'h42), .DATASIZE(8), .CNTSIZE(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .scl_in (scl_m),
    .sda_in (sda_bus),
    .sda_oe (sda_oe),
    .busy   (busy),
    .fifo   (fifo_bus)
  );

  assign sda_bus = sda_m & ~sda_oe;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // FIFO model (first-word fall-through)
  logic [7:0] fq[$];
  logic       fifo_clr = 1'b0;
  logic       fifo_push = 1'b0;
  logic [7:0] fifo_wdata = 8'h00;
  int         pop_cnt = 0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
    end else begin
      if (fifo_bus.doutR) begin
        if (fq.size() != 0) void'(fq.pop_front());
        pop_cnt <= pop_cnt + 1;
      end
      if (fifo_push) fq.push_back(fifo_wdata);
    end
    fifo_bus.dout  <= (fq.size() != 0) ? fq[0] : 8'h00;
    fifo_bus.doutV <= (fq.size() != 0);
    fifo_bus.cnt   <= 8'(fq.size());
  end

  // Invariant monitors
  int   oe_viol = 0;
  int   doutr_viol = 0;
  int   busy_cycles = 0;
  logic oe_prev = 1'b0;

  always @(negedge clk) begin
    if (sda_oe !== oe_prev && scl_m) oe_viol <= oe_viol + 1;
    if (fifo_bus.doutR && !fifo_bus.doutV) doutr_viol <= doutr_viol + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    oe_prev <= sda_oe;
  end

  // Scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  initial begin
    forever begin
      @(negedge clk);
      while (rx_q.size() != 0) begin
        logic [7:0] got;
        got = rx_q.pop_front();
        if (exp_q.size() == 0) begin
          check("rx_unexpected_byte", int'(got), -1);
        end else begin
          check("rx_byte", int'(got), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fifo_clear();
    fifo_clr = 1'b1;
    wait_clks(1);
    fifo_clr = 1'b0;
    wait_clks(1);
  endtask

  task automatic fifo_put(input logic [7:0] d);
    fifo_push  = 1'b1;
    fifo_wdata = d;
    wait_clks(1);
    fifo_push = 1'b0;
    wait_clks(1);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    b = sda_bus;  wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bit_v);
      b[i] = bit_v;
    end
  endtask

  task automatic addr_phase(input logic [7:0] a, output logic ack);
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(a[i]);
    read_bit(ack);
  endtask

  // Reads n bytes, ACKing all but the last which is NACKed.
  task automatic read_data(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      read_byte(b);
      rx_q.push_back(b);
      write_bit(k == n - 1);
    end
  endtask

  initial begin
    logic ack;
    logic [7:0] b;
    logic dummy;
    int p0, bc0;

    // reset state
    wait_clks(4);
    check("reset_sda_oe", int'(sda_oe), 0);
    check("reset_doutR", int'(fifo_bus.doutR), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    wait_clks(4);

    // 1: two words, ACK ACK NACK
    fifo_clear();
    fifo_put(8'hA5);
    fifo_put(8'h3C);
    p0 = pop_cnt;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    addr_phase(8'h85, ack);
    check("t1_addr_ack", int'(ack), 0);
    check("t1_busy_during", int'(busy), 1);
    read_data(3);
    i2c_stop();
    wait_clks(4);
    check("t1_pops", pop_cnt - p0, 2);
    check("t1_cnt_end", int'(fifo_bus.cnt), 0);
    check("t1_busy_after_stop", int'(busy), 0);
    check("t1_oe_after_stop", int'(sda_oe), 0);

    // 2: empty FIFO
    fifo_clear();
    p0 = pop_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    addr_phase(8'h85, ack);
    check("t2_addr_ack", int'(ack), 0);
    read_data(2);
    i2c_stop();
    wait_clks(4);
    check("t2_pops", pop_cnt - p0, 0);

    // 3: wrong address read, then write to our address
    fifo_put(8'h55);
    p0  = pop_cnt;
    bc0 = busy_cycles;
    addr_phase(8'h87, ack);
    check("t3_wrong_addr_nack", int'(ack), 1);
    i2c_stop();
    addr_phase(8'h84, ack);
    check("t3_write_nack", int'(ack), 1);
    i2c_stop();
    wait_clks(4);
    check("t3_busy_cycles", busy_cycles - bc0, 0);
    check("t3_pops", pop_cnt - p0, 0);

    // 4: reset mid-byte of 0x11
    fifo_clear();
    fifo_put(8'h11);
    fifo_put(8'h22);
    p0 = pop_cnt;
    exp_q.push_back(8'h02);
    addr_phase(8'h85, ack);
    check("t4_addr_ack", int'(ack), 0);
    read_byte(b);
    rx_q.push_back(b);
    write_bit(1'b0);
    read_bit(dummy);
    read_bit(dummy);
    check("t4_oe_before_reset", int'(sda_oe), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t4_oe_after_reset", int'(sda_oe), 0);
    check("t4_busy_after_reset", int'(busy), 0);
    wait_clks(3);
    reset = 1'b0;
    wait_clks(4);
    check("t4_pops_mid", pop_cnt - p0, 1);
    i2c_stop();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h22);
    addr_phase(8'h85, ack);
    check("t4_reread_ack", int'(ack), 0);
    read_data(2);
    i2c_stop();
    wait_clks(4);
    check("t4_pops_total", pop_cnt - p0, 2);
    check("t4_cnt_end", int'(fifo_bus.cnt), 0);

    // 5: NACK on cnt byte, repeated START, second read
    fifo_clear();
    fifo_put(8'h7E);
    p0 = pop_cnt;
    exp_q.push_back(8'h01);
    addr_phase(8'h85, ack);
    check("t5_addr_ack1", int'(ack), 0);
    read_data(1);
    wait_clks(4);
    check("t5_pops_first", pop_cnt - p0, 0);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h7E);
    addr_phase(8'h85, ack);
    check("t5_addr_ack2", int'(ack), 0);
    read_data(2);
    i2c_stop();
    wait_clks(4);
    check("t5_pops_total", pop_cnt - p0, 1);

    // 6: global invariants and scoreboard drain
    wait_clks(8);
    check("oe_change_scl_high", oe_viol, 0);
    check("doutR_without_doutV", doutr_viol, 0);
    check("sb_expected_left", exp_q.size(), 0);
    check("sb_received_left", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
